// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: CP0 exception codes,
// mem_exc flag positions, FSM states and the priority-encoder result record.
package exc_pkg;

   localparam logic [5:0] EXC_INT  = 6'h00;
   localparam logic [5:0] EXC_ADEL = 6'h04;
   localparam logic [5:0] EXC_ADES = 6'h05;
   localparam logic [5:0] EXC_SYS  = 6'h08;
   localparam logic [5:0] EXC_BP   = 6'h09;
   localparam logic [5:0] EXC_RI   = 6'h0a;
   localparam logic [5:0] EXC_OV   = 6'h0c;
   localparam logic [5:0] EXC_ERET = 6'h0e;

   // Bit positions inside mem_exc = {adel_if, ri, ov, sys, bp, adel_d, ades, eret}
   localparam int EXB_ADEL_IF = 7;
   localparam int EXB_RI      = 6;
   localparam int EXB_OV      = 5;
   localparam int EXB_SYS     = 4;
   localparam int EXB_BP      = 3;
   localparam int EXB_ADEL_D  = 2;
   localparam int EXB_ADES    = 1;
   localparam int EXB_ERET    = 0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      COMMIT   = 2'd2,
      REDIRECT = 2'd3
   } state_e;

   typedef struct packed {
      logic        hit;
      logic [5:0]  code;
      logic [31:0] badvaddr;
      logic        is_eret;
   } exc_sel_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the single exception or interrupt
// that the MEM instruction takes, with its code and bad virtual address.
module exc_prio_enc
   import exc_pkg::*;
(
   input  logic        mem_valid,
   input  logic        int_req,
   input  logic [7:0]  mem_exc,
   input  logic [31:0] mem_pc,
   input  logic [31:0] mem_daddr,
   output exc_sel_t    sel
);

   always_comb begin
      // NOTE: every field gets a default before the priority chain so no path leaves a latch behind.
      sel          = '0;
      sel.hit      = mem_valid & (int_req | (|mem_exc));
      if (int_req) begin
         sel.code     = EXC_INT;
      end else if (mem_exc[EXB_ADEL_IF]) begin
         sel.code     = EXC_ADEL;
         sel.badvaddr = mem_pc;
      end else if (mem_exc[EXB_RI]) begin
         sel.code     = EXC_RI;
      end else if (mem_exc[EXB_OV]) begin
         sel.code     = EXC_OV;
      end else if (mem_exc[EXB_SYS]) begin
         sel.code     = EXC_SYS;
      end else if (mem_exc[EXB_BP]) begin
         sel.code     = EXC_BP;
      end else if (mem_exc[EXB_ADEL_D]) begin
         sel.code     = EXC_ADEL;
         sel.badvaddr = mem_daddr;
      end else if (mem_exc[EXB_ADES]) begin
         sel.code     = EXC_ADES;
         sel.badvaddr = mem_daddr;
      end else if (mem_exc[EXB_ERET]) begin
         sel.code     = EXC_ERET;
         sel.is_eret  = 1'b1;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: latch the MEM-stage exception, wait for the AXI data
// port to drain, pulse the CP0 update with a flush, then hold the fetch redirect.
module exc_ctrl
   import exc_pkg::*;
#(
   parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
   parameter int          INT_SYNC  = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_indelayslot,
   input  logic [7:0]  mem_exc,
   input  logic [31:0] mem_daddr,
   input  logic        mem_busy,
   input  logic [5:0]  ext_int,
   input  logic [31:0] cp0_status,
   input  logic [31:0] cp0_cause,
   input  logic [31:0] cp0_epc,
   output logic        mem_kill,
   output logic        stall,
   output logic        flush,
   output logic        cp0_en,
   output logic [5:0]  cp0_exctype,
   output logic [31:0] cp0_pc,
   output logic [31:0] cp0_badvaddr,
   output logic        cp0_indelayslot,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        fetch_ready
);

   state_e      state_q, state_d;
   logic [5:0]  code_q, code_d;
   logic [31:0] pc_q, pc_d;
   logic        ds_q, ds_d;
   logic [31:0] badvaddr_q, badvaddr_d;
   logic        eret_q, eret_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic [5:0]  ext_int_q;
   logic        int_req;
   exc_sel_t    sel;

   generate
      if (INT_SYNC != 0) begin : g_int_sync
         logic [5:0] ext_int_d;
         assign ext_int_d = ext_int;
         always_ff @(posedge clk) begin
            if (rst) ext_int_q <= '0;
            else     ext_int_q <= ext_int_d;
         end
      end else begin : g_int_direct
         assign ext_int_q = ext_int;
      end
   endgenerate

   // IM[7:2] mask the hardware lines, IM[1:0] mask the software bits in Cause.
   assign int_req = cp0_status[0] & ~cp0_status[1] &
                    (|({ext_int_q, cp0_cause[9:8]} & cp0_status[15:8]));

   logic unused_cp0_bits;
   assign unused_cp0_bits = ^{cp0_status[31:16], cp0_status[7:2],
                              cp0_cause[31:10], cp0_cause[7:0]};

   exc_prio_enc u_prio_enc (
      .mem_valid (mem_valid),
      .int_req   (int_req),
      .mem_exc   (mem_exc),
      .mem_pc    (mem_pc),
      .mem_daddr (mem_daddr),
      .sel       (sel)
   );

   // State register and latched exception context.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q       <= IDLE;
         code_q        <= '0;
         pc_q          <= '0;
         ds_q          <= 1'b0;
         badvaddr_q    <= '0;
         eret_q        <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         code_q        <= code_d;
         pc_q          <= pc_d;
         ds_q          <= ds_d;
         badvaddr_q    <= badvaddr_d;
         eret_q        <= eret_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (sel.hit) state_d = mem_busy ? DRAIN : COMMIT;
         DRAIN:    if (!mem_busy) state_d = COMMIT;
         COMMIT:   state_d = REDIRECT;
         REDIRECT: if (fetch_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Context capture on the hit; the ERET target is read from EPC in COMMIT.
   always_comb begin
      code_d        = code_q;
      pc_d          = pc_q;
      ds_d          = ds_q;
      badvaddr_d    = badvaddr_q;
      eret_d        = eret_q;
      redirect_pc_d = redirect_pc_q;
      if (state_q == IDLE && sel.hit) begin
         code_d     = sel.code;
         pc_d       = mem_pc;
         ds_d       = mem_indelayslot;
         badvaddr_d = sel.badvaddr;
         eret_d     = sel.is_eret;
      end
      if (state_q == COMMIT) begin
         redirect_pc_d = eret_q ? cp0_epc : EXC_ENTRY;
      end
   end

   // Output decode.
   always_comb begin
      mem_kill        = sel.hit & (state_q == IDLE);
      stall           = (state_q != IDLE);
      flush           = 1'b0;
      cp0_en          = 1'b0;
      cp0_exctype     = '0;
      cp0_pc          = '0;
      cp0_badvaddr    = '0;
      cp0_indelayslot = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      if (state_q == COMMIT) begin
         flush           = 1'b1;
         cp0_en          = 1'b1;
         cp0_exctype     = code_q;
         cp0_pc          = pc_q;
         cp0_badvaddr    = badvaddr_q;
         cp0_indelayslot = ds_q;
      end
      if (state_q == REDIRECT) begin
         redirect_valid = 1'b1;
         redirect_pc    = redirect_pc_q;
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: each step drives inputs just after a rising
// edge and compares outputs against hand-computed values.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_indelayslot;
   logic [7:0]  mem_exc;
   logic [31:0] mem_daddr;
   logic        mem_busy;
   logic [5:0]  ext_int;
   logic [31:0] cp0_status;
   logic [31:0] cp0_cause;
   logic [31:0] cp0_epc;
   logic        mem_kill;
   logic        stall;
   logic        flush;
   logic        cp0_en;
   logic [5:0]  cp0_exctype;
   logic [31:0] cp0_pc;
   logic [31:0] cp0_badvaddr;
   logic        cp0_indelayslot;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_ready;

   int n_assert = 0;
   int n_fail   = 0;

   exc_ctrl #(
      .EXC_ENTRY (32'hBFC0_0380),
      .INT_SYNC  (1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_valid       (mem_valid),
      .mem_pc          (mem_pc),
      .mem_indelayslot (mem_indelayslot),
      .mem_exc         (mem_exc),
      .mem_daddr       (mem_daddr),
      .mem_busy        (mem_busy),
      .ext_int         (ext_int),
      .cp0_status      (cp0_status),
      .cp0_cause       (cp0_cause),
      .cp0_epc         (cp0_epc),
      .mem_kill        (mem_kill),
      .stall           (stall),
      .flush           (flush),
      .cp0_en          (cp0_en),
      .cp0_exctype     (cp0_exctype),
      .cp0_pc          (cp0_pc),
      .cp0_badvaddr    (cp0_badvaddr),
      .cp0_indelayslot (cp0_indelayslot),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .fetch_ready     (fetch_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      mem_valid       = 1'b0;
      mem_exc         = 8'h00;
      mem_busy        = 1'b0;
      mem_indelayslot = 1'b0;
      #1;
   endtask

   initial begin
      rst             = 1'b1;
      mem_pc          = '0;
      mem_daddr       = '0;
      ext_int         = '0;
      cp0_status      = '0;
      cp0_cause       = '0;
      cp0_epc         = '0;
      fetch_ready     = 1'b0;
      clear_mem();
      step();
      step();

      // Reset state
      check("rst_stall",    stall,          0);
      check("rst_flush",    flush,          0);
      check("rst_cp0_en",   cp0_en,         0);
      check("rst_exctype",  cp0_exctype,    0);
      check("rst_cp0_pc",   cp0_pc,         0);
      check("rst_rvalid",   redirect_valid, 0);
      check("rst_rpc",      redirect_pc,    0);
      check("rst_mem_kill", mem_kill,       0);
      rst = 1'b0;
      step();

      // ov, no outstanding AXI: COMMIT next cycle, redirect held 3 cycles
      mem_valid = 1'b1; mem_pc = 32'h8000_1000; mem_exc = 8'h20; mem_indelayslot = 1'b1;
      #1;
      check("ov_kill",  mem_kill, 1);
      check("ov_stall0", stall,   0);
      step();
      clear_mem();
      check("ov_cp0_en",   cp0_en,          1);
      check("ov_flush",    flush,           1);
      check("ov_stall",    stall,           1);
      check("ov_exctype",  cp0_exctype,     32'h0c);
      check("ov_cp0_pc",   cp0_pc,          32'h8000_1000);
      check("ov_ds",       cp0_indelayslot, 1);
      check("ov_rvalid_c", redirect_valid,  0);
      step();
      for (int i = 0; i < 3; i++) begin
         check("ov_rvalid", redirect_valid, 1);
         check("ov_rpc",    redirect_pc,    32'hBFC0_0380);
         check("ov_en_off", cp0_en,         0);
         check("ov_flush_off", flush,       0);
         check("ov_cp0pc_off", cp0_pc,      0);
         if (i == 2) fetch_ready = 1'b1;
         step();
      end
      fetch_ready = 1'b0;
      check("ov_idle_rvalid", redirect_valid, 0);
      check("ov_idle_rpc",    redirect_pc,    0);
      check("ov_idle_stall",  stall,          0);

      // ades with mem_busy high for 4 cycles; a later hit in DRAIN is ignored
      mem_valid = 1'b1; mem_pc = 32'h8000_1100; mem_exc = 8'h02;
      mem_daddr = 32'h0000_0003; mem_busy = 1'b1;
      #1;
      check("ades_kill", mem_kill, 1);
      step();
      mem_exc = 8'h20;
      for (int i = 0; i < 4; i++) begin
         mem_busy = (i < 3);
         #1;
         check("drain_stall",  stall,    1);
         check("drain_cp0_en", cp0_en,   0);
         check("drain_flush",  flush,    0);
         check("drain_kill",   mem_kill, 0);
         step();
      end
      clear_mem();
      check("ades_cp0_en",   cp0_en,       1);
      check("ades_stall",    stall,        1);
      check("ades_exctype",  cp0_exctype,  32'h05);
      check("ades_badvaddr", cp0_badvaddr, 32'h0000_0003);
      check("ades_cp0_pc",   cp0_pc,       32'h8000_1100);
      step();
      fetch_ready = 1'b1;
      check("ades_rvalid", redirect_valid, 1);
      check("ades_rpc",    redirect_pc,    32'hBFC0_0380);
      step();
      fetch_ready = 1'b0;
      check("ades_1cyc_rvalid", redirect_valid, 0);

      // eret redirects to EPC
      cp0_epc = 32'h8000_2000;
      mem_valid = 1'b1; mem_pc = 32'h8000_1200; mem_exc = 8'h01;
      step();
      clear_mem();
      check("eret_exctype", cp0_exctype, 32'h0e);
      check("eret_cp0_en",  cp0_en,      1);
      step();
      check("eret_rpc", redirect_pc, 32'h8000_2000);
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      cp0_epc = '0;

      // adel_if + ri + adel_d together: adel_if wins, badvaddr = pc
      mem_valid = 1'b1; mem_pc = 32'h8000_1301; mem_exc = 8'hC4; mem_daddr = 32'h1234_5678;
      step();
      clear_mem();
      check("multi_exctype",  cp0_exctype,  32'h04);
      check("multi_badvaddr", cp0_badvaddr, 32'h8000_1301);
      step();
      check("multi_rpc", redirect_pc, 32'hBFC0_0380);
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;

      // Pending interrupt held while no valid MEM instruction
      cp0_status = 32'h0000_0401; ext_int = 6'b000001;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("int_wait_kill",  mem_kill, 0);
         check("int_wait_stall", stall,    0);
         step();
      end
      mem_valid = 1'b1; mem_pc = 32'h8000_1400;
      #1;
      check("int_kill", mem_kill, 1);
      step();
      clear_mem();
      check("int_exctype",  cp0_exctype,  32'h00);
      check("int_cp0_en",   cp0_en,       1);
      check("int_cp0_pc",   cp0_pc,       32'h8000_1400);
      check("int_badvaddr", cp0_badvaddr, 0);
      step();
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;

      // INT_SYNC latency, then EXL masks the interrupt
      ext_int = '0;
      step();
      step();
      ext_int = 6'b000001; mem_valid = 1'b1; mem_pc = 32'h8000_1404;
      #1;
      check("int_sync_kill0", mem_kill, 0);
      step();
      check("int_sync_kill1", mem_kill, 1);
      cp0_status = 32'h0000_0403;
      #1;
      check("exl_kill", mem_kill, 0);
      step();
      check("exl_cp0_en", cp0_en, 0);
      check("exl_stall",  stall,  0);
      ext_int = '0; cp0_status = '0;
      clear_mem();
      step();

      // Reset in REDIRECT, then a normal ov
      mem_valid = 1'b1; mem_pc = 32'h8000_1500; mem_exc = 8'h20;
      step();
      clear_mem();
      step();
      check("rr_rvalid", redirect_valid, 1);
      rst = 1'b1;
      step();
      check("rr_rvalid0", redirect_valid, 0);
      check("rr_stall0",  stall,          0);
      check("rr_rpc0",    redirect_pc,    0);
      rst = 1'b0;
      mem_valid = 1'b1; mem_pc = 32'h8000_1600; mem_exc = 8'h20;
      #1;
      check("rr_kill", mem_kill, 1);
      step();
      clear_mem();
      check("rr_cp0_en",  cp0_en,      1);
      check("rr_exctype", cp0_exctype, 32'h0c);
      check("rr_cp0_pc",  cp0_pc,      32'h8000_1600);
      step();
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      check("rr_idle", stall, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
